// File: rtl/keypad_lock_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_lock_ctrl
//   Password-box controller behind a 4x4 keypad scanner. Debounces the
//   scanner's key code / any-column flag into single key events, collects
//   digit entries, checks them against a stored password and drives the
//   unlock / alarm / lockout status. The password can be changed while open.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   key_hit    in   high while any keypad column reads active
//   key[3:0]   in   scanner key code: 0-9 digit, A clear, B enter,
//                   C lock/abort, F set password, D/E unused
//   key_evt    out  one-cycle pulse per accepted (debounced) press
//   key_code   out  code captured with key_evt, held until the next event
//   digit_cnt  out  digits held in the entry buffer (0..LEN)
//   unlocked   out  high in OPEN and SET
//   set_mode   out  high in SET
//   alarm      out  high in LOCKOUT
//   ok_pulse   out  one-cycle pulse: correct entry or password stored
//   err_pulse  out  one-cycle pulse: rejected entry
//   fail_cnt   out  consecutive failures, saturating at MAX_FAIL
// -----------------------------------------------------------------------------
module keypad_lock_ctrl #(
  parameter int unsigned        LEN         = 4,
  parameter int unsigned        DEB_CYCLES  = 16,
  parameter int unsigned        MAX_FAIL    = 3,
  parameter int unsigned        LOCK_CYCLES = 1000,
  parameter logic [4*LEN-1:0]   DEFAULT_PW  = 16'h1234
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_hit,
  input  logic [3:0] key,
  output logic       key_evt,
  output logic [3:0] key_code,
  output logic [3:0] digit_cnt,
  output logic       unlocked,
  output logic       set_mode,
  output logic       alarm,
  output logic       ok_pulse,
  output logic       err_pulse,
  output logic [1:0] fail_cnt
);

  localparam int unsigned BW = 4 * LEN;
  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);

  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0] REL_MAX  = DW'(DEB_CYCLES);
  localparam logic [LW-1:0] LOCK_END = LW'(LOCK_CYCLES - 1);
  localparam logic [3:0]    LEN_C    = 4'(LEN);
  localparam logic [1:0]    FAIL_MAX = 2'(MAX_FAIL);

  localparam logic [3:0] K_CLR = 4'hA;
  localparam logic [3:0] K_ENT = 4'hB;
  localparam logic [3:0] K_LCK = 4'hC;
  localparam logic [3:0] K_SET = 4'hF;

  typedef enum logic [1:0] {
    ST_ENTRY,
    ST_OPEN,
    ST_SET,
    ST_LOCKOUT
  } state_e;

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  logic [3:0]    key_q;
  logic          hit_q;
  logic          pressed_q, pressed_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [DW-1:0] rel_q, rel_d;
  logic          key_evt_q;
  logic [3:0]    key_code_q;
  logic          stable;
  logic          fire;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    deb_d     = '0;
    rel_d     = '0;
    pressed_d = pressed_q;
    // The previous-cycle hit qualifier makes the first cycle of a press count
    // as sample zero, independent of what code the scanner showed while idle.
    stable    = key_hit && hit_q && (key == key_q);
    if (stable) deb_d = (deb_q == DEB_MAX) ? deb_q : deb_q + 1'b1;
    if (!key_hit) rel_d = (rel_q == REL_MAX) ? rel_q : rel_q + 1'b1;
    fire = (deb_d == DEB_MAX) && !pressed_q;
    if (fire) begin
      pressed_d = 1'b1;
    end else if (rel_d == REL_MAX) begin
      pressed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q      <= '0;
      hit_q      <= 1'b0;
      pressed_q  <= 1'b0;
      deb_q      <= '0;
      rel_q      <= '0;
      key_evt_q  <= 1'b0;
      key_code_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      key_q     <= key;
      hit_q     <= key_hit;
      pressed_q <= pressed_d;
      deb_q     <= deb_d;
      rel_q     <= rel_d;
      key_evt_q <= fire;
      if (fire) key_code_q <= key;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM (consumes the registered event one cycle after key_evt)
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [BW-1:0] pw_q, pw_d;
  logic [3:0]    dc_q, dc_d;
  logic [1:0]    fail_q, fail_d;
  logic [LW-1:0] lock_q, lock_d;
  logic          ok_d, err_d;
  logic          ok_q, err_q, unl_q, set_q, alarm_q;
  logic          is_digit;

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    pw_d     = pw_q;
    dc_d     = dc_q;
    fail_d   = fail_q;
    lock_d   = '0;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    is_digit = (key_code_q <= 4'd9);

    // Digit collection and clear are shared by ENTRY and SET.
    if (key_evt_q && (state_q == ST_ENTRY || state_q == ST_SET)) begin
      if (is_digit && dc_q < LEN_C) begin
        buf_d = (buf_q << 4) | BW'(key_code_q);
        dc_d  = dc_q + 4'd1;
      end else if (key_code_q == K_CLR) begin
        buf_d = '0;
        dc_d  = '0;
      end
    end

    unique case (state_q)
      ST_ENTRY: begin
        if (key_evt_q && key_code_q == K_ENT) begin
          if (dc_q == LEN_C && buf_q == pw_q) begin
            ok_d    = 1'b1;
            fail_d  = '0;
            state_d = ST_OPEN;
          end else begin
            err_d  = 1'b1;
            fail_d = fail_q + 2'd1;
            if (fail_d == FAIL_MAX) state_d = ST_LOCKOUT;
          end
        end
      end
      ST_OPEN: begin
        if (key_evt_q && key_code_q == K_LCK) state_d = ST_ENTRY;
        if (key_evt_q && key_code_q == K_SET) state_d = ST_SET;
      end
      ST_SET: begin
        if (key_evt_q && key_code_q == K_ENT) begin
          if (dc_q == LEN_C) begin
            pw_d    = buf_q;
            ok_d    = 1'b1;
            state_d = ST_OPEN;
          end else begin
            err_d = 1'b1;
          end
        end else if (key_evt_q && key_code_q == K_LCK) begin
          state_d = ST_OPEN;
        end
      end
      ST_LOCKOUT: begin
        if (lock_q == LOCK_END) begin
          state_d = ST_ENTRY;
          fail_d  = '0;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end
      default: state_d = ST_ENTRY;
    endcase

    // Any state change discards a partial entry.
    if (state_d != state_q) begin
      buf_d = '0;
      dc_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ENTRY;
      buf_q   <= '0;
      // NOTE: the password register is reset on purpose: a reset must restore the factory password.
      pw_q    <= DEFAULT_PW;
      dc_q    <= '0;
      fail_q  <= '0;
      lock_q  <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      unl_q   <= 1'b0;
      set_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      pw_q    <= pw_d;
      dc_q    <= dc_d;
      fail_q  <= fail_d;
      lock_q  <= lock_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      unl_q   <= (state_d == ST_OPEN) || (state_d == ST_SET);
      set_q   <= (state_d == ST_SET);
      alarm_q <= (state_d == ST_LOCKOUT);
    end
  end

  assign key_evt   = key_evt_q;
  assign key_code  = key_code_q;
  assign digit_cnt = dc_q;
  assign unlocked  = unl_q;
  assign set_mode  = set_q;
  assign alarm     = alarm_q;
  assign ok_pulse  = ok_q;
  assign err_pulse = err_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keypad_lock_ctrl
//   Self-checking bench for keypad_lock_ctrl (LEN=4, DEB_CYCLES=4,
//   MAX_FAIL=3, LOCK_CYCLES=20). Key sequences are table-driven records of
//   {key, expected status one cycle after key_evt}; debounce, lockout timing
//   and mid-operation reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_keypad_lock_ctrl;

  localparam int DEB  = 4;
  localparam int LOCK = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_hit;
  logic [3:0] key;
  logic       key_evt;
  logic [3:0] key_code;
  logic [3:0] digit_cnt;
  logic       unlocked, set_mode, alarm, ok_pulse, err_pulse;
  logic [1:0] fail_cnt;

  keypad_lock_ctrl #(
    .LEN(4), .DEB_CYCLES(DEB), .MAX_FAIL(3), .LOCK_CYCLES(LOCK), .DEFAULT_PW(16'h1234)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_hit(key_hit), .key(key),
    .key_evt(key_evt), .key_code(key_code), .digit_cnt(digit_cnt),
    .unlocked(unlocked), .set_mode(set_mode), .alarm(alarm),
    .ok_pulse(ok_pulse), .err_pulse(err_pulse), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] k;
    logic       ok, err;
    logic [3:0] dc;
    logic       unl, setm, alm;
    logic [1:0] fail;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Snapshot of status taken the cycle after each accepted key event.
  logic       s_ok, s_err, s_unl, s_setm, s_alm;
  logic [3:0] s_dc;
  logic [1:0] s_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] k, input bit ok, input bit err, input int dc,
                              input bit unl, input bit setm, input bit alm, input int fl);
    vec_t v;
    v.k = k; v.ok = ok; v.err = err; v.dc = 4'(dc);
    v.unl = unl; v.setm = setm; v.alm = alm; v.fail = 2'(fl);
    return v;
  endfunction

  // Press, wait for the debounced event, snapshot status one cycle later, release.
  task automatic press(input logic [3:0] k);
    bit got;
    got = 0;
    @(negedge clk);
    key = k;
    key_hit = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (key_evt) begin
        got = 1;
        break;
      end
    end
    check($sformatf("evt_seen key=%h", k), 32'(got), 32'd1);
    check($sformatf("key_code key=%h", k), 32'(key_code), 32'(k));
    @(posedge clk); #1;
    s_ok = ok_pulse; s_err = err_pulse; s_dc = digit_cnt; s_unl = unlocked;
    s_setm = set_mode; s_alm = alarm; s_fail = fail_cnt;
    check("ok_err_exclusive", 32'(ok_pulse & err_pulse), 32'd0);
    @(negedge clk);
    key_hit = 1'b0;
    repeat (DEB + 1) @(posedge clk);
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      press(tbl[i].k);
      check($sformatf("%s row%0d key=%h {ok,err,dc,unl,set,alm,fail}", tag, i, tbl[i].k),
            32'({s_ok, s_err, s_dc, s_unl, s_setm, s_alm, s_fail}),
            32'({tbl[i].ok, tbl[i].err, tbl[i].dc, tbl[i].unl, tbl[i].setm, tbl[i].alm, tbl[i].fail}));
    end
    tbl.delete();
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({key_evt, key_code, digit_cnt, unlocked, set_mode, alarm, ok_pulse, err_pulse, fail_cnt}),
          32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  evt_n, evt_cyc;
    logic [3:0] evt_code;
    bit  saw_evt;

    rst_n = 1'b0; key_hit = 1'b0; key = 4'h0;
    #1;
    check_all_zero("reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // ---- Debounce: 3-cycle press gives nothing; glitchy long hold gives one event on sample 4.
    evt_n = 0; evt_cyc = 0; evt_code = 4'h0;
    @(negedge clk); key = 4'h5; key_hit = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (key_evt) evt_n++;
    end
    @(negedge clk); key_hit = 1'b0;
    repeat (6) @(posedge clk);
    check("short_press_no_evt", 32'(evt_n), 32'd0);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      key_hit = !(c inside {[15:16], [30:31], [44:45]});
      @(posedge clk); #1;
      if (key_evt) begin
        evt_n++;
        if (evt_n == 1) begin
          evt_cyc = c;
          evt_code = key_code;
        end
      end
    end
    @(negedge clk); key_hit = 1'b0;
    repeat (6) @(posedge clk); #1;
    check("bounce_single_evt", 32'(evt_n), 32'd1);
    check("bounce_evt_latency", 32'(evt_cyc), 32'(DEB));
    check("bounce_evt_code", 32'(evt_code), 32'h5);
    check("bounce_digit_taken", 32'(digit_cnt), 32'd1);
    press(4'hA);
    check("clear_after_bounce", 32'(s_dc), 32'd0);

    // ---- Main sequences: {key, ok, err, dc, unl, set, alm, fail}
    tbl.push_back(mk(4'h1, 0,0,1, 0,0,0, 0));
    tbl.push_back(mk(4'h2, 0,0,2, 0,0,0, 0));
    tbl.push_back(mk(4'h3, 0,0,3, 0,0,0, 0));
    tbl.push_back(mk(4'h4, 0,0,4, 0,0,0, 0));
    tbl.push_back(mk(4'hB, 1,0,0, 1,0,0, 0));   // default password opens
    tbl.push_back(mk(4'h5, 0,0,0, 1,0,0, 0));   // digits ignored in OPEN
    tbl.push_back(mk(4'hC, 0,0,0, 0,0,0, 0));
    tbl.push_back(mk(4'h1, 0,0,1, 0,0,0, 0));
    tbl.push_back(mk(4'h2, 0,0,2, 0,0,0, 0));
    tbl.push_back(mk(4'hB, 0,1,2, 0,0,0, 1));   // short entry rejected, buffer kept
    tbl.push_back(mk(4'h9, 0,0,3, 0,0,0, 1));
    tbl.push_back(mk(4'h9, 0,0,4, 0,0,0, 1));
    tbl.push_back(mk(4'hA, 0,0,0, 0,0,0, 1));
    tbl.push_back(mk(4'h1, 0,0,1, 0,0,0, 1));
    tbl.push_back(mk(4'h2, 0,0,2, 0,0,0, 1));
    tbl.push_back(mk(4'h3, 0,0,3, 0,0,0, 1));
    tbl.push_back(mk(4'h4, 0,0,4, 0,0,0, 1));
    tbl.push_back(mk(4'h5, 0,0,4, 0,0,0, 1));   // fifth digit ignored
    tbl.push_back(mk(4'hB, 1,0,0, 1,0,0, 0));
    tbl.push_back(mk(4'hF, 0,0,0, 1,1,0, 0));
    tbl.push_back(mk(4'h9, 0,0,1, 1,1,0, 0));
    tbl.push_back(mk(4'hB, 0,1,1, 1,1,0, 0));   // short store rejected, fail untouched
    tbl.push_back(mk(4'hC, 0,0,0, 1,0,0, 0));   // abort SET
    tbl.push_back(mk(4'hF, 0,0,0, 1,1,0, 0));
    tbl.push_back(mk(4'h7, 0,0,1, 1,1,0, 0));
    tbl.push_back(mk(4'h7, 0,0,2, 1,1,0, 0));
    tbl.push_back(mk(4'h0, 0,0,3, 1,1,0, 0));
    tbl.push_back(mk(4'h1, 0,0,4, 1,1,0, 0));
    tbl.push_back(mk(4'hB, 1,0,0, 1,0,0, 0));   // password now 7701
    tbl.push_back(mk(4'hC, 0,0,0, 0,0,0, 0));
    tbl.push_back(mk(4'h1, 0,0,1, 0,0,0, 0));
    tbl.push_back(mk(4'h2, 0,0,2, 0,0,0, 0));
    tbl.push_back(mk(4'h3, 0,0,3, 0,0,0, 0));
    tbl.push_back(mk(4'h4, 0,0,4, 0,0,0, 0));
    tbl.push_back(mk(4'hB, 0,1,4, 0,0,0, 1));   // old password rejected
    tbl.push_back(mk(4'hA, 0,0,0, 0,0,0, 1));
    tbl.push_back(mk(4'h7, 0,0,1, 0,0,0, 1));
    tbl.push_back(mk(4'h7, 0,0,2, 0,0,0, 1));
    tbl.push_back(mk(4'h0, 0,0,3, 0,0,0, 1));
    tbl.push_back(mk(4'h1, 0,0,4, 0,0,0, 1));
    tbl.push_back(mk(4'hB, 1,0,0, 1,0,0, 0));
    tbl.push_back(mk(4'hC, 0,0,0, 0,0,0, 0));
    tbl.push_back(mk(4'hF, 0,0,0, 0,0,0, 0));   // F ignored in ENTRY
    tbl.push_back(mk(4'hD, 0,0,0, 0,0,0, 0));
    for (int r = 0; r < 3; r++) begin
      if (r > 0) tbl.push_back(mk(4'hA, 0,0,0, 0,0,0, r));
      tbl.push_back(mk(4'h1, 0,0,1, 0,0,0, r));
      tbl.push_back(mk(4'h2, 0,0,2, 0,0,0, r));
      tbl.push_back(mk(4'h3, 0,0,3, 0,0,0, r));
      tbl.push_back(mk(4'h5, 0,0,4, 0,0,0, r));
      if (r < 2) tbl.push_back(mk(4'hB, 0,1,4, 0,0,0, r + 1));
      else       tbl.push_back(mk(4'hB, 0,1,0, 0,0,1, 3));   // third failure locks out
    end
    run_table("main");

    // ---- Lockout timing: entered at snapshot edge T; press() returned at T+DEB+1.
    saw_evt = 0;
    for (int c = DEB + 2; c <= LOCK; c++) begin
      @(negedge clk);
      key = 4'h1;
      key_hit = (c >= 7 && c <= 14);
      @(posedge clk); #1;
      if (key_evt) saw_evt = 1;
      if (c < LOCK) check($sformatf("lockout_hold c=%0d {alm,dc}", c), 32'({alarm, digit_cnt}), 32'h10);
      else          check("lockout_exit {alm,fail,unl}", 32'({alarm, fail_cnt, unlocked}), 32'd0);
    end
    check("debounce_runs_in_lockout", 32'(saw_evt), 32'd1);
    repeat (4) @(posedge clk);

    tbl.push_back(mk(4'h7, 0,0,1, 0,0,0, 0));
    tbl.push_back(mk(4'h7, 0,0,2, 0,0,0, 0));
    tbl.push_back(mk(4'h0, 0,0,3, 0,0,0, 0));
    tbl.push_back(mk(4'h1, 0,0,4, 0,0,0, 0));
    tbl.push_back(mk(4'hB, 1,0,0, 1,0,0, 0));   // password survives lockout
    tbl.push_back(mk(4'hF, 0,0,0, 1,1,0, 0));
    tbl.push_back(mk(4'h7, 0,0,1, 1,1,0, 0));
    run_table("post_lock");

    // ---- Reset during SET entry
    #3 rst_n = 1'b0;
    #1 check_all_zero("reset_in_set");
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    tbl.push_back(mk(4'h1, 0,0,1, 0,0,0, 0));
    tbl.push_back(mk(4'h2, 0,0,2, 0,0,0, 0));
    tbl.push_back(mk(4'h3, 0,0,3, 0,0,0, 0));
    tbl.push_back(mk(4'h4, 0,0,4, 0,0,0, 0));
    tbl.push_back(mk(4'hB, 1,0,0, 1,0,0, 0));   // default password restored
    tbl.push_back(mk(4'hC, 0,0,0, 0,0,0, 0));
    tbl.push_back(mk(4'hB, 0,1,0, 0,0,0, 1));
    tbl.push_back(mk(4'hB, 0,1,0, 0,0,0, 2));
    tbl.push_back(mk(4'hB, 0,1,0, 0,0,1, 3));
    run_table("post_reset");

    // ---- Reset during LOCKOUT
    #3 rst_n = 1'b0;
    #1 check_all_zero("reset_in_lockout");
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("after_reset_lockout {alm,fail,dc}", 32'({alarm, fail_cnt, digit_cnt}), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_lock_ctrl.md
Name: keypad_lock_ctrl

Overview:
- Password-box controller that sits downstream of the 4x4 keypad row/column scanner.
- Takes the scanner's decoded 4-bit key code plus a raw "any column active" flag, debounces them into single key events, and collects digit entries.
- Compares each completed entry against a stored password and drives the unlock, alarm and lockout status outputs.
- Supports changing the password while unlocked.

Parameters:
- LEN, 4, number of password digits (1..8); buffer width is 4*LEN.
- DEB_CYCLES, 16, consecutive stable clk cycles needed to accept a press or a release (>=2).
- MAX_FAIL, 3, consecutive failed entries that trigger lockout (>=1).
- LOCK_CYCLES, 1000, lockout duration in clk cycles.
- DEFAULT_PW, 16'h1234, password loaded at reset; one BCD digit per nibble, MSB nibble is the first digit.

Ports:
- clk  in  1  system clock; all flops on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_hit  in  1  high while any keypad column reads active.
- key  in  4  key code from the scanner; 0-9 are digits, A=clear, B=enter, C=lock/abort, F=set password; D and E are unused.
- key_evt  out  1  one-cycle pulse when a debounced press is accepted.
- key_code  out  4  code registered with key_evt; holds until the next event.
- digit_cnt  out  4  digits currently held in the entry buffer (0..LEN).
- unlocked  out  1  high in the OPEN and SET states.
- set_mode  out  1  high in the SET state.
- alarm  out  1  high in the LOCKOUT state.
- ok_pulse  out  1  one-cycle pulse on a correct entry or a successful password store.
- err_pulse  out  1  one-cycle pulse on a rejected entry.
- fail_cnt  out  2  consecutive failures, saturating at MAX_FAIL.

Behaviour:
- Reset values:
  - All pulses, counters, key_code, digit_cnt, fail_cnt and the buffer are 0.
  - unlocked, set_mode and alarm are 0.
  - State is ENTRY; stored password is DEFAULT_PW.
  - An asserted rst_n mid-operation aborts everything, including lockout, immediately.
- Debounce press:
  - deb_cnt increments while key_hit=1 and key equals the previous cycle's key.
  - deb_cnt clears when key_hit=0 or key changes.
  - When deb_cnt reaches DEB_CYCLES-1 and the pressed flag is 0: key_evt=1 for 1 cycle, key_code<=key, pressed<=1.
  - Latency from first stable sample to key_evt is DEB_CYCLES cycles.
- Debounce release:
  - pressed clears only after key_hit=0 for DEB_CYCLES consecutive cycles.
  - A held key produces exactly one event.
  - A bounce shorter than DEB_CYCLES produces no second event.
- Event processing: key events are consumed by the FSM in the cycle after key_evt. All FSM outputs are registered.
- ENTRY state:
  - Digit: shift the nibble into the buffer and increment digit_cnt. When digit_cnt=LEN the digit is ignored; no error is raised.
  - A: clear buffer, digit_cnt=0.
  - B with digit_cnt=LEN and buffer==password: ok_pulse, fail_cnt=0, go to OPEN.
  - B with a mismatch or digit_cnt<LEN: err_pulse and fail_cnt+1. If the new fail_cnt==MAX_FAIL, go to LOCKOUT; otherwise stay in ENTRY.
  - C, D, E, F: ignored.
- OPEN state:
  - C: go to ENTRY.
  - F: go to SET.
  - All other keys are ignored.
- SET state:
  - Digits and A behave as in ENTRY.
  - B with digit_cnt=LEN: password<=buffer, ok_pulse, go to OPEN.
  - B with digit_cnt<LEN: err_pulse, stay in SET; fail_cnt is untouched.
  - C: go to OPEN; the password is unchanged.
- LOCKOUT state:
  - All key events are ignored; debounce keeps running.
  - lock_cnt counts LOCK_CYCLES cycles, then the FSM returns to ENTRY with fail_cnt=0.
- Buffer and digit_cnt clear on every state transition.
- ok_pulse and err_pulse are never high in the same cycle.

Test Plan:
- Reset, default password: bench uses DEB_CYCLES=4, LOCK_CYCLES=20. Press 1,2,3,4 then B -> one key_evt per press, digit_cnt steps 1..4, then ok_pulse=1 and unlocked=1; digit_cnt=0.
- Debounce: key 5 held for 3 cycles, released, then held for 50 cycles with 2-cycle glitches at key_hit=0 -> exactly one key_evt with key_code=5, issued on the 4th stable cycle.
- Failures and lockout: enter 1,2,3,5+B three times -> three err_pulse, fail_cnt 1,2,3; alarm=1. Keys are ignored for 20 cycles, then alarm=0 and fail_cnt=0.
- Short entry and clear:
  - 1,2+B -> err_pulse, fail_cnt=1.
  - 9,9,A,1,2,3,4,5+B -> digit 5 is ignored, ok_pulse=1.
- Change password: unlock, then F, 7,7,0,1, B -> ok_pulse=1, set_mode drops. Then C, then 1,2,3,4+B -> err_pulse; 7,7,0,1+B -> unlocked=1.
- Reset mid-operation: assert rst_n=0 during LOCKOUT and during SET entry -> all outputs return to 0 at once; password reverts to 1234.
